// File: rtl/mmio_data_fifo_if.sv
// Handshake bundle between MMIO decode, the data FIFO and the read-response mux.
// The master drives push/pop/clear requests; the slave (the FIFO) returns head word and status.
interface mmio_data_fifo_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic [DATA_W-1:0] pop_data;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;
  logic [63:0]       status;

  modport master (
    output push, push_data, pop, clr_err,
    input  pop_data, empty, full, count, overflow, underflow, status
  );

  modport slave (
    input  push, push_data, pop, clr_err,
    output pop_data, empty, full, count, overflow, underflow, status
  );
endinterface

// File: rtl/mmio_data_fifo.sv
// First-word-fall-through data FIFO for the MMIO user data address, with sticky
// overflow/underflow flags and a packed status word; head word visible in the pop cycle.
module mmio_data_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input logic           clk,
  input logic           rst,
  mmio_data_fifo_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  logic empty;
  logic full;
  logic push_ok;
  logic pop_ok;
  logic ov_set;
  logic un_set;

  // A push into a full FIFO is still taken when a pop frees the head slot in the same cycle.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    push_ok = bus.push && (!full || bus.pop);
    pop_ok  = bus.pop && !empty;
    ov_set  = bus.push && full && !bus.pop;
    un_set  = bus.pop && empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A new error in the same cycle as a clear keeps the flag set.
      if (ov_set)           overflow  <= 1'b1;
      else if (bus.clr_err) overflow  <= 1'b0;
      if (un_set)           underflow <= 1'b1;
      else if (bus.clr_err) underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.push_data;
  end

  // Storage is never reset, so the head is masked whenever nothing valid is stored.
  assign bus.pop_data  = empty ? '0 : mem[rd_ptr];
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
  assign bus.status    = {44'b0, underflow, overflow, full, empty,
                          {(16 - CNT_W){1'b0}}, count};
endmodule

// File: tb/tb_mmio_data_fifo.sv
// Directed bench for mmio_data_fifo: a queue model checked every cycle plus literal pins.
module tb_mmio_data_fifo;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;

  mmio_data_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  mmio_data_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an ordered queue of stored words plus two sticky flags.
  logic [DATA_W-1:0] mq[$];
  logic              m_ov;
  logic              m_un;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic [DATA_W-1:0] d, input logic o, input logic c);
    bit was_full;
    bit was_empty;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (o && !was_empty) void'(mq.pop_front());
    if (p && (!was_full || o)) mq.push_back(d);
    if (p && was_full && !o) m_ov = 1'b1;
    else if (c)              m_ov = 1'b0;
    if (o && was_empty)      m_un = 1'b1;
    else if (c)              m_un = 1'b0;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      logic [63:0] e_data;
      logic [63:0] e_stat;
      logic        e_empty;
      logic        e_full;
      e_empty = (mq.size() == 0);
      e_full  = (mq.size() == DEPTH);
      e_data  = e_empty ? 64'h0 : mq[0];
      e_stat  = {44'b0, m_un, m_ov, e_full, e_empty, 16'(mq.size())};
      chk("m_pop_data",  bus.pop_data,         e_data);
      chk("m_empty",     64'(bus.empty),       64'(e_empty));
      chk("m_full",      64'(bus.full),        64'(e_full));
      chk("m_count",     64'(bus.count),       64'(mq.size()));
      chk("m_overflow",  64'(bus.overflow),    64'(m_ov));
      chk("m_underflow", 64'(bus.underflow),   64'(m_un));
      chk("m_status",    bus.status,           e_stat);
    end
  end

  // One clock of stimulus; optionally pins pop_data to a literal during the cycle.
  task automatic step(input logic p, input logic [DATA_W-1:0] d, input logic o, input logic c,
                      input bit do_chk, input logic [63:0] exp, input string name);
    bus.push      = p;
    bus.push_data = d;
    bus.pop       = o;
    bus.clr_err   = c;
    @(negedge clk);
    if (do_chk) chk(name, bus.pop_data, exp);
    @(posedge clk);
    model_step(p, d, o, c);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic push_w(input logic [63:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 64'h0, "");
  endtask

  task automatic pop_w(input logic [63:0] exp, input string name);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, exp, name);
  endtask

  task automatic idle();
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, "");
  endtask

  initial begin
    bus.push      = 1'b0;
    bus.push_data = '0;
    bus.pop       = 1'b0;
    bus.clr_err   = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    started = 1;

    // Reset state
    idle();
    chk("rst_empty",    64'(bus.empty),  64'h1);
    chk("rst_full",     64'(bus.full),   64'h0);
    chk("rst_count",    64'(bus.count),  64'h0);
    chk("rst_pop_data", bus.pop_data,    64'h0);
    chk("rst_status",   bus.status,      64'h0000_0000_0001_0000);

    // Three words in, three out in order
    push_w(64'h1111);
    push_w(64'h2222);
    push_w(64'h3333);
    chk("abc_count", 64'(bus.count), 64'h3);
    pop_w(64'h1111, "pop_a");
    pop_w(64'h2222, "pop_b");
    pop_w(64'h3333, "pop_c");
    chk("abc_empty", 64'(bus.empty), 64'h1);
    chk("abc_count0", 64'(bus.count), 64'h0);

    // Fill, overflow with DEAD, drain
    for (int i = 0; i < DEPTH; i++) push_w(64'h100 + 64'(i));
    push_w(64'hDEAD);
    chk("ovf_full",   64'(bus.full),     64'h1);
    chk("ovf_count",  64'(bus.count),    64'h8);
    chk("ovf_flag",   64'(bus.overflow), 64'h1);
    chk("ovf_status", bus.status,        64'h0000_0000_0002_0008 | 64'h0000_0000_0004_0000);
    for (int i = 0; i < DEPTH; i++) pop_w(64'h100 + 64'(i), "ovf_drain");
    chk("ovf_drained", 64'(bus.empty), 64'h1);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, "");
    chk("ovf_clr", 64'(bus.overflow), 64'h0);

    // Full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push_w(64'h200 + 64'(i));
    step(1'b1, 64'hBEEF, 1'b1, 1'b0, 1'b1, 64'h200, "fullpp_head");
    chk("fullpp_count", 64'(bus.count),    64'h8);
    chk("fullpp_ovf",   64'(bus.overflow), 64'h0);
    for (int i = 1; i < DEPTH; i++) pop_w(64'h200 + 64'(i), "fullpp_drain");
    pop_w(64'hBEEF, "fullpp_beef");
    chk("fullpp_empty", 64'(bus.empty), 64'h1);

    // Underflow, clear, and set-wins-over-clear
    pop_w(64'h0, "unf_pop_data");
    chk("unf_set", 64'(bus.underflow), 64'h1);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, "");
    chk("unf_clr", 64'(bus.underflow), 64'h0);
    step(1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, "");
    chk("unf_set_wins", 64'(bus.underflow), 64'h1);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, "");

    // Empty with simultaneous push and pop: push taken, pop rejected
    step(1'b1, 64'h77, 1'b1, 1'b0, 1'b1, 64'h0, "emptypp_data");
    chk("emptypp_count", 64'(bus.count),     64'h1);
    chk("emptypp_unf",   64'(bus.underflow), 64'h1);
    pop_w(64'h77, "emptypp_word");
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, "");

    // Reset mid-sequence
    for (int i = 0; i < 5; i++) push_w(64'h400 + 64'(i));
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_count", 64'(bus.count), 64'h0);
    chk("mid_rst_empty", 64'(bus.empty), 64'h1);
    chk("mid_rst_data",  bus.pop_data,   64'h0);
    push_w(64'h55);
    pop_w(64'h55, "post_rst_55");

    // Pointer wrap through push/pop pairs
    for (int i = 0; i < 20; i++) begin
      push_w(64'h300 + 64'(i));
      pop_w(64'h300 + 64'(i), "wrap");
    end
    chk("wrap_empty", 64'(bus.empty), 64'h1);

    idle();
    started = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
